// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared limits and helper functions for the post-processing
//                unit (output saturation bounds, window-counter width,
//                saturate and signed-max helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    // Window counter width for a given largest pooling window (counts 0..N-1).
    function automatic int win_cnt_w(input int pool_max);
        return (pool_max <= 2) ? 1 : $clog2(pool_max);
    endfunction

    // Largest representable signed output value for an OUT_W-bit lane.
    function automatic longint qmax(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    // Smallest representable signed output value for an OUT_W-bit lane.
    function automatic longint qmin(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

    // Clamp a wide signed value into the OUT_W-bit signed range.
    function automatic longint sat(input longint v, input int out_w);
        if (v > qmax(out_w)) begin
            return qmax(out_w);
        end else if (v < qmin(out_w)) begin
            return qmin(out_w);
        end
        return v;
    endfunction

    // Signed maximum of two values.
    function automatic longint smax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_lane
//  Description : One channel of the post-processing unit: ReLU, arithmetic
//                right-shift requantisation (optionally rounded), saturation,
//                running-max register and registered output lane.
//                Rounding is enabled by defining PPU_ROUND_EN; otherwise the
//                shift truncates toward minus infinity.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_lane
    import ppu_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_W-1:0]    x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_en_i,
    input  logic               beat_i,     // accepted beat that is not cleared
    input  logic               first_i,    // beat opens a window
    input  logic               last_i,     // beat closes a window
    input  logic               clear_i,
    output logic [OUT_W-1:0]   out_o
);

    logic signed [IN_W:0]    w_r;
    logic signed [IN_W:0]    w_adj;
    logic signed [IN_W:0]    w_sh;
    logic signed [OUT_W-1:0] w_q;
    logic signed [OUT_W-1:0] w_max;
    logic signed [OUT_W-1:0] run_q;
    logic signed [OUT_W-1:0] run_d;
    logic        [OUT_W-1:0] out_q;
    logic        [OUT_W-1:0] out_d;

    // Quantise the incoming word and fold it into the running maximum.
    always_comb begin
        // Sign-extend by one bit so rounding can never overflow.
        w_r = {x_i[IN_W-1], x_i};
        if (relu_en_i && x_i[IN_W-1]) begin
            w_r = '0;
        end

        w_adj = w_r;
`ifdef PPU_ROUND_EN
        if ((shift_i != '0) && (int'(shift_i) <= IN_W)) begin
            w_adj = w_r + ({{IN_W{1'b0}}, 1'b1} << (shift_i - 1'b1));
        end
`endif

        if (int'(shift_i) >= IN_W) begin
            w_sh = {(IN_W+1){w_adj[IN_W]}};
        end else begin
            w_sh = w_adj >>> shift_i;
        end

        w_q   = OUT_W'(sat(longint'(w_sh), OUT_W));
        w_max = OUT_W'(smax(longint'(run_q), longint'(w_q)));

        run_d = run_q;
        out_d = out_q;
        if (clear_i) begin
            run_d = '0;
        end else if (beat_i) begin
            run_d = first_i ? w_q : w_max;
            if (last_i) begin
                out_d = first_i ? w_q : w_max;
            end
        end
    end

    // Running-max and output lane registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            out_q <= '0;
        end else begin
            run_q <= run_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/ppu_array.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_array
//  Description : Multi-lane post-processing unit between the PE-array drain
//                and the output buffer writer. Holds the pooling window
//                counter, valid/ready handshakes and clear handling; the
//                per-lane datapath lives in ppu_lane.
//                Optional feature macro: PPU_ROUND_EN (round half up).
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_array
    import ppu_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 8,
    parameter int SHIFT_W  = 6,
    parameter int POOL_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_W-1:0]        in_data,
    input  logic [SHIFT_W-1:0]           cfg_shift,
    input  logic                         cfg_relu_en,
    input  logic                         cfg_pool_en,
    input  logic [$clog2(POOL_MAX+1)-1:0] cfg_pool_size,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_W-1:0]       out_data,
    output logic                         busy
);

    localparam int CW  = win_cnt_w(POOL_MAX);
    localparam int PSW = $clog2(POOL_MAX + 1);

    logic [CW-1:0]  win_cnt_q;
    logic [CW-1:0]  win_cnt_d;
    logic           out_valid_q;
    logic           out_valid_d;
    logic [PSW-1:0] w_n_eff;
    logic [PSW-1:0] w_n_m1;
    logic [PSW-1:0] w_win_ext;
    logic           w_accept;
    logic           w_beat;
    logic           w_first;
    logic           w_last;

    assign in_ready = !out_valid_q || out_ready;

    // Effective window length, window position and next handshake state.
    always_comb begin
        w_n_eff = PSW'(1);
        if (cfg_pool_en && (cfg_pool_size != '0)) begin
            w_n_eff = (cfg_pool_size > PSW'(POOL_MAX)) ? PSW'(POOL_MAX) : cfg_pool_size;
        end
        w_n_m1    = w_n_eff - PSW'(1);
        w_win_ext = PSW'(win_cnt_q);

        w_accept = in_valid && in_ready;
        w_beat   = w_accept && !clear;       // clear drops a coincident beat
        w_first  = (win_cnt_q == '0);
        // ">=" so an illegal mid-window size change still closes the window.
        w_last   = (w_win_ext >= w_n_m1);

        win_cnt_d = win_cnt_q;
        if (clear) begin
            win_cnt_d = '0;
        end else if (w_beat) begin
            win_cnt_d = w_last ? '0 : (win_cnt_q + CW'(1));
        end

        out_valid_d = out_valid_q;
        if (w_beat && w_last) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Window counter and output-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (win_cnt_q != '0);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        ppu_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .x_i       (in_data[gi*IN_W +: IN_W]),
            .shift_i   (cfg_shift),
            .relu_en_i (cfg_relu_en),
            .beat_i    (w_beat),
            .first_i   (w_first),
            .last_i    (w_last),
            .clear_i   (clear),
            .out_o     (out_data[gi*OUT_W +: OUT_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_array
//  Description : Directed self-checking bench for ppu_array (4 lanes,
//                32-bit in, 8-bit out). Expected values are hand-computed;
//                the PPU_ROUND_EN macro selects the rounding expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_array;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [127:0] in_data;
    logic [5:0]  cfg_shift;
    logic        cfg_relu_en;
    logic        cfg_pool_en;
    logic [2:0]  cfg_pool_size;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_cmp;
    int n_err;

    ppu_array #(
        .LANES    (4),
        .IN_W     (32),
        .OUT_W    (8),
        .SHIFT_W  (6),
        .POOL_MAX (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .cfg_shift     (cfg_shift),
        .cfg_relu_en   (cfg_relu_en),
        .cfg_pool_en   (cfg_pool_en),
        .cfg_pool_size (cfg_pool_size),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane 0 is the least significant word.
    task automatic set4(input int a, input int b, input int c, input int d);
        in_data = {d[31:0], c[31:0], b[31:0], a[31:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_shift = 6'd0;
        cfg_relu_en = 1'b0;
        cfg_pool_en = 1'b0;
        cfg_pool_size = 3'd0;
        clear = 1'b0;
        out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        // N = 1, shift 4, saturation both ways.
        cfg_shift = 6'd4;
        in_valid = 1'b1;
        set4(256, -256, 40000, -40000);
        tick();
        chk("n1_valid", 32'(out_valid), 32'd1);
        chk("n1_data",  out_data,       32'h807FF010);

        // ReLU with shift 0, back-to-back.
        cfg_shift = 6'd0;
        cfg_relu_en = 1'b1;
        set4(-5, 5, 200, -200);
        tick();
        chk("relu_valid", 32'(out_valid), 32'd1);
        chk("relu_data",  out_data,       32'h007F0500);

        // Shift 1: rounding vs truncation.
        cfg_relu_en = 1'b0;
        cfg_shift = 6'd1;
        set4(3, -3, 0, 255);
        tick();
`ifdef PPU_ROUND_EN
        chk("shift1_data", out_data, 32'h7F00FF02);
`else
        chk("shift1_data", out_data, 32'h7F00FE01);
`endif

        // Shift beyond the input width gives the sign fill.
        cfg_shift = 6'd40;
        set4(-1000, 1000, -1, 0);
        tick();
        chk("bigshift_data", out_data, 32'h00FF00FF);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Pool window of 4.
        cfg_shift = 6'd0;
        cfg_pool_en = 1'b1;
        cfg_pool_size = 3'd4;
        chk("pool_busy0", 32'(busy), 32'd0);
        in_valid = 1'b1;
        set4(3, -1, 100, 0);
        tick();
        chk("pool_busy1", 32'(busy), 32'd1);
        set4(-7, -2, 200, 0);
        tick();
        chk("pool_busy2", 32'(busy), 32'd1);
        set4(12, -3, 300, 0);
        tick();
        chk("pool_busy3",  32'(busy),      32'd1);
        chk("pool_early",  32'(out_valid), 32'd0);
        set4(5, -4, -300, 0);
        tick();
        chk("pool_busy4", 32'(busy),      32'd0);
        chk("pool_valid", 32'(out_valid), 32'd1);
        chk("pool_data",  out_data,       32'h007FFF0C);
        in_valid = 1'b0;
        tick();
        chk("pool_drain", 32'(out_valid), 32'd0);

        // Backpressure: window completes with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set4(k, k, k, k);
            tick();
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_ready", 32'(in_ready),  32'd0);
        chk("stall_data",  out_data,       32'h04040404);
        set4(9, 9, 9, 9);
        tick();
        tick();
        chk("stall_hold_data",  out_data,      32'h04040404);
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        chk("stall_hold_busy",  32'(busy),     32'd0);

        // Release together with a completing (N = 1) beat: valid stays high.
        cfg_pool_en = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_data",  out_data,       32'h09090909);

        // Pool enabled with size 0 behaves as N = 1.
        cfg_pool_en = 1'b1;
        cfg_pool_size = 3'd0;
        set4(11, 11, 11, 11);
        tick();
        chk("size0_busy", 32'(busy), 32'd0);
        chk("size0_data", out_data,  32'h0B0B0B0B);

        // Size beyond POOL_MAX clamps to 4 beats.
        cfg_pool_size = 3'd7;
        set4(1, 1, 1, 1);
        tick();
        set4(20, 20, 20, 20);
        tick();
        set4(2, 2, 2, 2);
        tick();
        chk("clamp_early", 32'(out_valid), 32'd0);
        set4(3, 3, 3, 3);
        tick();
        chk("clamp_valid", 32'(out_valid), 32'd1);
        chk("clamp_data",  out_data,       32'h14141414);

        // Clear after 2 of 4 beats; the coincident beat is dropped.
        cfg_pool_size = 3'd4;
        set4(50, 50, 50, 50);
        tick();
        set4(60, 60, 60, 60);
        tick();
        chk("clr_busy_pre", 32'(busy), 32'd1);
        clear = 1'b1;
        set4(100, 100, 100, 100);
        tick();
        clear = 1'b0;
        chk("clr_busy",  32'(busy),      32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            set4(k, k, k, k);
            tick();
        end
        chk("clr_early", 32'(out_valid), 32'd0);
        set4(4, 4, 4, 4);
        tick();
        chk("clr_valid_post", 32'(out_valid), 32'd1);
        chk("clr_data",       out_data,       32'h04040404);

        // Asynchronous reset mid-window.
        set4(70, 70, 70, 70);
        tick();
        set4(80, 80, 80, 80);
        tick();
        chk("prerst_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  out_data,       32'h0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        set4(5, 5, 5, 5);
        tick();
        set4(-3, -3, -3, -3);
        tick();
        set4(7, 7, 7, 7);
        tick();
        set4(6, 6, 6, 6);
        tick();
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_data",  out_data,       32'h07070707);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppu_array.md
# ppu_array

Multi-lane, parametrised post-processing unit on the accumulator-to-activation path. It takes LANES signed accumulator words per beat and applies, per lane, optional ReLU, arithmetic right-shift requantisation with saturation, and optional max-pooling over a configurable number of consecutive beats. Results leave on a registered OUT_W-bit-per-lane stream. Both sides use valid/ready handshakes, so the block can sit between the PE-array drain and the output GLB writer under backpressure.

## Interface
Parameters:
- LANES, 4, number of parallel channels
- IN_W, 32, signed accumulator width per lane
- OUT_W, 8, signed output width per lane
- SHIFT_W, 6, width of the shift amount
- POOL_MAX, 4, largest pooling window, in beats

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W]
- cfg_shift  in  SHIFT_W  right-shift amount
- cfg_relu_en  in  1  clamp negatives to 0 before the shift
- cfg_pool_en  in  1  enable max-pooling
- cfg_pool_size  in  $clog2(POOL_MAX+1)  window length in beats
- clear  in  1  synchronous abort of a partial window
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane i occupies bits [i*OUT_W +: OUT_W]
- busy  out  1  a partial window is held (win_cnt != 0)

## Operation
- Quantise, per lane, combinationally on in_data:
  - r = cfg_relu_en ? max(x, 0) : x
  - Compute in IN_W+1 bits: q = r >>> cfg_shift, arithmetic shift.
  - If cfg_shift >= IN_W, q is the sign fill (0 or -1).
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Effective window length N:
  - N = 1 when cfg_pool_en = 0 or cfg_pool_size = 0.
  - Otherwise N = min(cfg_pool_size, POOL_MAX).
- Per-lane running max register run[i]; window counter win_cnt counts 0..N-1.
- On an accepted beat:
  - If win_cnt == 0, load run = q.
  - Otherwise run = max(run, q), signed compare.
  - If win_cnt == N-1: out_data <= (N == 1 ? q : max(run, q)), out_valid <= 1, win_cnt <= 0.
  - Otherwise win_cnt <= win_cnt + 1.
- in_ready = !out_valid || out_ready.
- out_valid clears on out_valid && out_ready, unless a new window completes in the same cycle. In that case out_valid stays 1 and out_data updates.
- clear:
  - Sets win_cnt <= 0 and discards run.
  - Does not touch out_valid or out_data.
  - If clear and an accepted beat occur in the same cycle, clear wins and the beat is dropped.
- Configuration inputs are sampled on every accepted beat. Changing cfg_pool_size or cfg_pool_en while busy = 1 is illegal; the expected sequence is clear, then change. If win_cnt >= N after an illegal change, the next accepted beat completes the window.

## Timing
- Reset values: out_valid = 0, out_data = 0, win_cnt = 0, run = 0, busy = 0. in_ready = 1 after reset.
- Latency: out_valid rises the cycle after the Nth beat of a window is accepted (1 cycle for N = 1).
- Throughput: 1 beat per cycle while out_ready = 1. With N = 1, output beats match input beats one-to-one.
- Stall: with out_ready = 0 and out_valid = 1, in_ready = 0, and run and win_cnt hold.
- Asserting rst mid-window or mid-stall discards everything immediately.

## Configuration
- Macro PPU_ROUND_EN.
- Defined: round half up. Before the shift, add 2^(cfg_shift-1) when 0 < cfg_shift <= IN_W; the addition is done in IN_W+1 bits so it cannot overflow.
- Undefined: truncation (floor) only.
- Saturation and every other behaviour are identical in both builds.

## Structure
- Package ppu_pkg:
  - output limits QMAX and QMIN as functions of OUT_W
  - window-count width
  - saturate and signed-max helper functions
- Sub-module ppu_lane, instantiated LANES times. It holds the ReLU, shift, round and saturate logic plus the run register and output lane register.
- ppu_array top holds win_cnt, the handshake logic and the clear handling.

## Test plan
- N = 1, shift = 4, relu_en = 0, lane inputs {256, -256, 40000, -40000} -> next cycle out = {16, -16, 127, -128}.
- relu_en = 1, shift = 0, input -5 -> 0. With PPU_ROUND_EN: shift = 1, input 3 -> 2; without the macro the same case gives 1.
- pool_en = 1, size = 4, beats lane 0 = {3, -7, 12, 5} -> a single output of 12 one cycle after beat 4; busy = 1 during beats 1-3 only.
- out_ready held 0 after a window completes: in_ready = 0 and out_data is stable. Raise out_ready together with the next window's last beat -> out_valid stays 1 and the new value appears.
- clear after 2 of 4 beats, then 4 fresh beats {1, 2, 3, 4} -> output 4, with no contribution from the discarded beats.
- rst asserted mid-window -> all outputs 0 immediately. After release, a full window produces the correct maximum.
